// File: rtl/turn_signal_arbiter_if.sv
// turn_signal_arbiter_if: request inputs and lamp/status outputs of the turn signal arbiter
//   left, right     turn requests (level)
//   LA, LB, LC      left lamps, LA innermost
//   RA, RB, RC      right lamps, RA innermost
//   busy            a sequence is in progress
//   tick            one-cycle step strobe
//   master modport: request driver / observer; slave modport: the arbiter
interface turn_signal_arbiter_if;
   logic left, right;
   logic LA, LB, LC, RA, RB, RC;
   logic busy, tick;
   modport master(output left, right, input LA, LB, LC, RA, RB, RC, busy, tick);
   modport slave(input left, right, output LA, LB, LC, RA, RB, RC, busy, tick);
endinterface

// File: rtl/turn_signal_arbiter.sv
// turn_signal_arbiter: arbitrates left/right turn requests into sequential three-lamp sweeps
//   TICK_DIV   clk_sys cycles per step tick (2..65535)
//   clk_sys    system clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        turn_signal_arbiter_if.slave: left/right requests in; lamps, busy, tick out
//   Macro TSA_HAZARD_EN: when defined, simultaneous pending requests run both sides together
//   (HAZARD); when undefined, a 1-bit round-robin pointer (reset to left) picks one side and
//   the other side stays pending.
module turn_signal_arbiter #(
   parameter int TICK_DIV = 8
) (
   input logic clk_sys,
   input logic reset_n,
   turn_signal_arbiter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, LEFT, RIGHT, HAZARD} state_t;
   state_t state, state_n;
   logic [15:0] cnt, cnt_n;
   logic [1:0] phase, phase_n;
   logic [2:0] mask_n, lamp_l, lamp_r;
   logic pend_l, pend_r, clr_l, clr_r, tick, busy;
`ifndef TSA_HAZARD_EN
   logic rr, rr_n;
`endif
   assign {bus.LC, bus.LB, bus.LA} = lamp_l;
   assign {bus.RC, bus.RB, bus.RA} = lamp_r;
   assign bus.busy = busy;
   assign bus.tick = tick;
   assign cnt_n = (cnt == 16'(TICK_DIV - 1)) ? '0 : cnt + 16'd1;
   // thermometer pattern for the phase being entered: 0->000, 1->001, 2->011, 3->111
   assign mask_n = {phase_n == 2'd3, phase_n[1], phase_n != 2'd0};
   always_comb begin
      state_n = state;
      phase_n = phase;
      clr_l = 1'b0;
      clr_r = 1'b0;
`ifndef TSA_HAZARD_EN
      rr_n = rr;
`endif
      if (tick && state == IDLE) begin
         if (pend_l && pend_r) begin
`ifdef TSA_HAZARD_EN
            state_n = HAZARD;
            clr_l = 1'b1;
            clr_r = 1'b1;
`else
            state_n = rr ? RIGHT : LEFT;
            clr_l = !rr;
            clr_r = rr;
            rr_n = !rr;
`endif
         end else if (pend_l) begin
            state_n = LEFT;
            clr_l = 1'b1;
         end else if (pend_r) begin
            state_n = RIGHT;
            clr_r = 1'b1;
         end
         phase_n = (state_n == IDLE) ? 2'd0 : 2'd1;
      end else if (tick) begin
         state_n = (phase == 2'd3) ? IDLE : state;
         phase_n = (phase == 2'd3) ? 2'd0 : phase + 2'd1;
      end
   end
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         cnt <= '0;
         tick <= 1'b0;
         pend_l <= 1'b0;
         pend_r <= 1'b0;
         state <= IDLE;
         phase <= 2'd0;
         busy <= 1'b0;
         lamp_l <= 3'b000;
         lamp_r <= 3'b000;
`ifndef TSA_HAZARD_EN
         rr <= 1'b0;
`endif
      end else begin
         cnt <= cnt_n;
         tick <= cnt_n == 16'(TICK_DIV - 1);
         // a grant clear wins over a request arriving on the same edge
         pend_l <= !clr_l && (pend_l || bus.left);
         pend_r <= !clr_r && (pend_r || bus.right);
         state <= state_n;
         phase <= phase_n;
         busy <= state_n != IDLE;
         lamp_l <= (state_n == LEFT || state_n == HAZARD) ? mask_n : 3'b000;
         lamp_r <= (state_n == RIGHT || state_n == HAZARD) ? mask_n : 3'b000;
`ifndef TSA_HAZARD_EN
         rr <= rr_n;
`endif
      end
   end
endmodule

// File: tb/tb_turn_signal_arbiter.sv
// tb_turn_signal_arbiter: directed and randomized checks of turn_signal_arbiter against a behavioural model
module tb_turn_signal_arbiter;
   localparam int TD = 4;
   logic clk_sys = 1'b0;
   logic reset_n = 1'b0;
   int total = 0;
   int bad = 0;
   turn_signal_arbiter_if bus();
   turn_signal_arbiter #(.TICK_DIV(TD)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));
   always #5 clk_sys = ~clk_sys;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a sequence is described by which sides are lit and a step 0..3
   int m_cnt, m_step;
   bit m_pl, m_pr, m_sl, m_sr, m_rr;
   always @(posedge clk_sys or negedge reset_n) begin
      bit pl, pr, sl, sr, rr;
      int step;
      if (!reset_n) begin
         m_cnt <= 0; m_step <= 0; m_pl <= 0; m_pr <= 0; m_sl <= 0; m_sr <= 0; m_rr <= 0;
      end else begin
         pl = m_pl | bus.left;
         pr = m_pr | bus.right;
         sl = m_sl; sr = m_sr; rr = m_rr; step = m_step;
         if (m_cnt == TD - 1) begin
            if (step == 0) begin
               if (m_pl && m_pr) begin
`ifdef TSA_HAZARD_EN
                  sl = 1; sr = 1; pl = 0; pr = 0;
`else
                  sl = !rr; sr = rr;
                  if (rr) pr = 0; else pl = 0;
                  rr = !rr;
`endif
                  step = 1;
               end else if (m_pl) begin
                  sl = 1; sr = 0; pl = 0; step = 1;
               end else if (m_pr) begin
                  sl = 0; sr = 1; pr = 0; step = 1;
               end
            end else if (step == 3) begin
               step = 0; sl = 0; sr = 0;
            end else step = step + 1;
         end
         m_pl <= pl; m_pr <= pr; m_sl <= sl; m_sr <= sr; m_rr <= rr; m_step <= step;
         m_cnt <= (m_cnt + 1) % TD;
      end
   end

   always @(negedge clk_sys) begin
      int pat;
      pat = (1 << m_step) - 1;
      chk("tick", int'(bus.tick), int'(reset_n && m_cnt == TD - 1));
      chk("busy", int'(bus.busy), int'(m_step != 0));
      chk("left_lamps", int'({bus.LC, bus.LB, bus.LA}), m_sl ? pat : 0);
      chk("right_lamps", int'({bus.RC, bus.RB, bus.RA}), m_sr ? pat : 0);
   end

   int ll[64], rl[64], bz[64], tk[64];

   // reset, then release with the given requests held for the first cycle only
   task automatic start(input logic l, input logic r);
      reset_n = 1'b0;
      bus.left = 1'b0;
      bus.right = 1'b0;
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      bus.left = l;
      bus.right = r;
   endtask

   // record n cycles after release; rk>0 pulses right during cycle rk
   task automatic run_rec(input int n, input int rk);
      for (int k = 1; k <= n; k++) begin
         @(negedge clk_sys);
         if (k == 1) begin bus.left = 1'b0; bus.right = 1'b0; end
         ll[k] = int'({bus.LC, bus.LB, bus.LA});
         rl[k] = int'({bus.RC, bus.RB, bus.RA});
         bz[k] = int'(bus.busy);
         tk[k] = int'(bus.tick);
         if (rk > 0) bus.right = (k == rk);
      end
   endtask

   initial begin
      int nb;
      bus.left = 1'b0;
      bus.right = 1'b0;
      #2;
      chk("reset_lamps", int'({bus.LC, bus.LB, bus.LA, bus.RC, bus.RB, bus.RA}), 0);
      chk("reset_busy_tick", int'({bus.busy, bus.tick}), 0);
      // single left pulse
      start(1'b1, 1'b0);
      run_rec(20, 0);
      chk("first_tick_k3", tk[3], 1);
      chk("no_tick_k2", tk[2], 0);
      chk("l_p1", ll[4], 1);
      chk("l_p2", ll[8], 3);
      chk("l_p3", ll[12], 7);
      chk("l_off", ll[16], 0);
      nb = 0;
      for (int k = 1; k <= 20; k++) nb += bz[k] + rl[k];
      chk("busy_cycles", nb, 12);
      // simultaneous pulse
      start(1'b1, 1'b1);
      run_rec(36, 0);
`ifdef TSA_HAZARD_EN
      chk("hz_p1", ll[4] * 8 + rl[4], 9);
      chk("hz_p2", ll[8] * 8 + rl[8], 27);
      chk("hz_p3", ll[12] * 8 + rl[12], 63);
      chk("hz_off", ll[16] * 8 + rl[16] + bz[20], 0);
`else
      chk("rr_left_first", ll[4] * 8 + rl[4], 8);
      chk("rr_left_p3", ll[12], 7);
      nb = 0;
      for (int k = 16; k <= 19; k++) nb += bz[k];
      chk("rr_gap", nb, 0);
      chk("rr_right_p1", ll[20] * 8 + rl[20], 1);
      chk("rr_right_p3", rl[28], 7);
      chk("rr_right_off", rl[32] + bz[32], 0);
`endif
      // right pulse while left is at phase 2
      start(1'b1, 1'b0);
      run_rec(28, 9);
      chk("mid_l_p3", ll[12] * 8 + rl[12], 56);
      chk("mid_off", ll[16] + rl[16] + bz[16], 0);
      chk("mid_r_p1", ll[20] * 8 + rl[20], 1);
      // reset in the middle of a sequence
      start(1'b1, 1'b1);
      run_rec(8, 0);
      #2 reset_n = 1'b0;
      #1;
      chk("rst_lamps", int'({bus.LC, bus.LB, bus.LA, bus.RC, bus.RB, bus.RA}), 0);
      chk("rst_busy_tick", int'({bus.busy, bus.tick}), 0);
      repeat (2) @(negedge clk_sys);
      reset_n = 1'b1;
      run_rec(24, 0);
      nb = 0;
      for (int k = 1; k <= 24; k++) nb += bz[k] + ll[k] + rl[k];
      chk("no_resume", nb, 0);
      // continuously held left: repeating 001,011,111,000
      start(1'b1, 1'b0);
      for (int k = 1; k <= 40; k++) begin
         @(negedge clk_sys);
         ll[k] = int'({bus.LC, bus.LB, bus.LA});
      end
      bus.left = 1'b0;
      chk("hold_2nd_p1", ll[20], 1);
      chk("hold_2nd_off", ll[32], 0);
      chk("hold_3rd_p1", ll[36], 1);
      // randomized traffic against the model
      for (int k = 0; k < 1500; k++) begin
         @(negedge clk_sys);
         bus.left = ($urandom_range(0, 9) == 0);
         bus.right = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 499) == 0) begin
            #2 reset_n = 1'b0;
            @(negedge clk_sys);
            reset_n = 1'b1;
         end
      end
      @(negedge clk_sys);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/turn_signal_arbiter.md
TURN_SIGNAL_ARBITER -- requirements
Module: turn_signal_arbiter

Interface
REQ-001 Parameter: TICK_DIV, default 8, number of clk_sys cycles per step tick; legal range 2..65535.
REQ-002 clk_sys  input  1  system clock; all state updates on its rising edge.
REQ-003 reset_n  input  1  reset, asynchronous, active-low.
REQ-004 left  input  1  left turn request, level, sampled every clk_sys edge.
REQ-005 right  input  1  right turn request, level, sampled every clk_sys edge.
REQ-006 LA, LB, LC  output  1 each  left lamps, registered; LA is innermost.
REQ-007 RA, RB, RC  output  1 each  right lamps, registered; RA is innermost.
REQ-008 busy  output  1  high whenever the FSM is not in IDLE, registered.
REQ-009 tick  output  1  one-cycle step strobe, registered, for observation.

Function
REQ-010 The prescaler SHALL count 0..TICK_DIV-1 and wrap. tick SHALL be high for exactly the one cycle in which the count equals TICK_DIV-1.
REQ-011 Pending flags pend_l and pend_r SHALL be set on any edge where left or right, respectively, is sampled high. They SHALL hold until cleared by a grant. Within one cycle, a grant clear SHALL take precedence over a set.
REQ-012 The FSM SHALL have states IDLE, LEFT, RIGHT and HAZARD, plus a 2-bit phase counter. FSM and phase SHALL change only on edges where tick is high.
REQ-013 Grant from IDLE on tick:
- both pend_l and pend_r set: HAZARD;
- only pend_l: LEFT;
- only pend_r: RIGHT;
- neither: remain in IDLE.
On every grant, phase SHALL become 1 and the served pending flag(s) SHALL clear.
REQ-014 In LEFT, RIGHT or HAZARD, each tick SHALL advance phase 1->2->3. On the tick at phase 3 the FSM SHALL return to IDLE with phase 0.
REQ-015 Lamp patterns, phase p:
- {LC,LB,LA} = (1<<p)-1 when in LEFT or HAZARD, otherwise 000;
- {RC,RB,RA} = (1<<p)-1 when in RIGHT or HAZARD, otherwise 000;
- sequence for p = 1, 2, 3 is 001, 011, 111.
REQ-016 Lamp outputs SHALL be registered. They SHALL change on the same edge as the state/phase update; there is no additional latency.
REQ-017 A sequence SHALL NOT be aborted or altered by new requests. Requests arriving mid-sequence SHALL be latched and evaluated at the first tick after the return to IDLE. This guarantees at least one all-off tick period between sequences.
REQ-018 A request held high continuously SHALL produce back-to-back sequences of the form 001, 011, 111, 000 repeated.
REQ-019 busy SHALL be high exactly while the state is LEFT, RIGHT or HAZARD.

Reset
REQ-020 While reset_n is low, all of the following SHALL be 0 immediately, independent of clk_sys:
- prescaler and phase;
- pend_l and pend_r;
- all six lamp outputs;
- busy and tick;
- the round-robin pointer (REQ-023).
The state SHALL be IDLE.
REQ-021 Reset asserted mid-sequence SHALL extinguish all lamps and discard pending requests.
REQ-022 After reset_n rises, the first tick SHALL occur in the TICK_DIV-th cycle.

Configuration
REQ-023 Macro TSA_HAZARD_EN:
- Defined: REQ-013 applies; simultaneous pending requests yield HAZARD.
- Undefined: HAZARD is not implemented. When both flags are pending, grant SHALL go to the side selected by a 1-bit round-robin pointer (reset value selects left) and clear only that side's flag. The pointer SHALL toggle on each such contested grant. The loser's flag SHALL stay pending.

Verification (TICK_DIV=4)
REQ-024 One-cycle left pulse after reset -> {LC,LB,LA} = 001, 011, 111, 000 on four consecutive ticks 4 cycles apart; R lamps stay 000; busy is high for 12 cycles.
REQ-025 left and right high in the same cycle, TSA_HAZARD_EN defined -> both sides show 001, 011, 111 simultaneously, then 000.
REQ-026 Same stimulus, TSA_HAZARD_EN undefined -> full left sequence, one off period (busy low 4 cycles), then full right sequence.
REQ-027 right pulse while LEFT is at phase 2 -> left completes to 111 then 000; right sequence starts on the next tick.
REQ-028 reset_n driven low while both sides show 011 -> all lamps, busy and tick are 0 within the same cycle; no sequence resumes after release without a new request.
